// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: walks NUM_TAPS coefficient/sample addresses per input
// sample, drives the MAC datapath enables, flushes the pipeline and captures
// the scaled accumulator result.
// Optional feature: define FIR_SEQ_SATURATE_EN to saturate result_out to
// signed 24 bits instead of plain truncation.
module fir_tap_sequencer #(
  parameter int unsigned NUM_TAPS     = 64,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned PIPE_LAT     = 7,
  parameter int unsigned RESULT_SHIFT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seq_en,
  input  logic              data_valid_stb,
  input  logic              overrun_clr,
  input  logic [47:0]       accum_in,
  output logic              sample_we,
  output logic              rd_en,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [ADDR_W-1:0] sample_addr,
  output logic              coef_zero,
  output logic              fir_en,
  output logic              fir_clr,
  output logic              busy,
  output logic              result_valid,
  output logic [23:0]       result_out,
  output logic              overrun
);

  localparam int unsigned CNT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(PIPE_LAT);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] k_next;
  logic [CNT_W-1:0]  drain_cnt;
  logic              strobe;

  assign k_next = k + 1'b1;
  assign strobe = data_valid_stb & seq_en;

`ifdef FIR_SEQ_SATURATE_EN
  // Arithmetic shift, clamped when the discarded bits are not a sign extension
  function automatic logic [23:0] shape(input logic [47:0] a);
    logic [47:0] sh;
    sh = $unsigned($signed(a) >>> RESULT_SHIFT);
    if ((&sh[47:23]) || !(|sh[47:23])) return sh[23:0];
    return sh[47] ? 24'h800000 : 24'h7FFFFF;
  endfunction
`else
  // Plain slice; bits outside it wrap away
  function automatic logic [23:0] shape(input logic [47:0] a);
    return a[RESULT_SHIFT +: 24];
  endfunction

  logic unused_accum;
  assign unused_accum = ^accum_in;
`endif

  // Sequencer FSM with registered datapath controls (outputs set for the next state)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      k            <= '0;
      drain_cnt    <= '0;
      sample_we    <= 1'b0;
      rd_en        <= 1'b0;
      coef_addr    <= '0;
      sample_addr  <= '0;
      coef_zero    <= 1'b0;
      fir_en       <= 1'b0;
      fir_clr      <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_out   <= '0;
    end else begin
      sample_we    <= 1'b0;
      rd_en        <= 1'b0;
      fir_en       <= 1'b0;
      fir_clr      <= 1'b0;
      coef_zero    <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            state       <= LOAD;
            busy        <= 1'b1;
            sample_we   <= 1'b1;
            fir_clr     <= 1'b1;
            sample_addr <= wr_ptr;
            k           <= '0;
          end
        end
        LOAD: begin
          state       <= RUN;
          rd_en       <= 1'b1;
          coef_addr   <= '0;
          sample_addr <= wr_ptr;
        end
        RUN: begin
          // fir_en follows rd_en one cycle late to cover the memory read latency
          fir_en <= 1'b1;
          if (k == LAST_TAP) begin
            state     <= DRAIN;
            coef_zero <= 1'b1;
            drain_cnt <= '0;
          end else begin
            rd_en       <= 1'b1;
            k           <= k_next;
            coef_addr   <= k_next;
            sample_addr <= wr_ptr - k_next;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state        <= DONE;
            result_valid <= 1'b1;
            result_out   <= shape(accum_in);
            wr_ptr       <= wr_ptr + 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
            fir_en    <= 1'b1;
            coef_zero <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a strobe outside IDLE is dropped and flagged; set beats clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (strobe && (state != IDLE)) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: timeline reference model on the
// default instance, vector tables for result scaling and 4-tap addressing.
module tb_fir_tap_sequencer;

  localparam int NT = 64;
  localparam int PL = 7;
  localparam int RS = 16;

  logic        clk;
  logic        reset;
  logic        seq_en;
  logic        data_valid_stb;
  logic        stb_s;
  logic        overrun_clr;
  logic [47:0] accum_in;

  logic        sample_we, rd_en, coef_zero, fir_en, fir_clr, busy, result_valid, overrun;
  logic [5:0]  coef_addr, sample_addr;
  logic [23:0] result_out;

  logic        s_sample_we, s_rd_en, s_coef_zero, s_fir_en, s_fir_clr, s_busy, s_result_valid, s_overrun;
  logic [1:0]  s_coef_addr, s_sample_addr;
  logic [23:0] s_result_out;

  fir_tap_sequencer dut (
    .clk(clk), .reset(reset), .seq_en(seq_en), .data_valid_stb(data_valid_stb),
    .overrun_clr(overrun_clr), .accum_in(accum_in), .sample_we(sample_we), .rd_en(rd_en),
    .coef_addr(coef_addr), .sample_addr(sample_addr), .coef_zero(coef_zero), .fir_en(fir_en),
    .fir_clr(fir_clr), .busy(busy), .result_valid(result_valid), .result_out(result_out),
    .overrun(overrun)
  );

  fir_tap_sequencer #(.NUM_TAPS(4), .ADDR_W(2), .PIPE_LAT(7), .RESULT_SHIFT(16)) dut_s (
    .clk(clk), .reset(reset), .seq_en(seq_en), .data_valid_stb(stb_s),
    .overrun_clr(overrun_clr), .accum_in(accum_in), .sample_we(s_sample_we), .rd_en(s_rd_en),
    .coef_addr(s_coef_addr), .sample_addr(s_sample_addr), .coef_zero(s_coef_zero), .fir_en(s_fir_en),
    .fir_clr(s_fir_clr), .busy(s_busy), .result_valid(s_result_valid), .result_out(s_result_out),
    .overrun(s_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state: cycle of the current LOAD (-1 when idle)
  int          m_load;
  int          m_wp;
  logic        m_ovr;
  logic [23:0] m_res;

  typedef struct {
    logic [47:0] acc;
    logic [23:0] exp_trunc;
    logic [23:0] exp_sat;
  } res_vec_t;

  typedef struct {
    logic [1:0] load_addr;
    logic [1:0] run_addr [4];
  } addr_vec_t;

  res_vec_t  rv [8];
  addr_vec_t av [5];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] exp_slice(input logic [47:0] a);
`ifdef FIR_SEQ_SATURATE_EN
    longint v;
    v = longint'($signed(a));
    v = v / 65536;
    if (v * 65536 > longint'($signed(a))) v = v - 1;
    if (v > 64'sd8388607) return 24'h7FFFFF;
    if (v < -64'sd8388608) return 24'h800000;
    return 24'(v);
`else
    return 24'(a >> RS);
`endif
  endfunction

  task automatic model_reset();
    m_load = -1;
    m_wp   = 0;
    m_ovr  = 1'b0;
    m_res  = '0;
  endtask

  // Expected outputs from the position t within the per-sample timeline
  task automatic check_model();
    int t;
    t = (m_load >= 0) ? cyc - m_load : -1;
    chk("busy",         48'(busy),         48'(t >= 0 && t <= NT + PL + 2));
    chk("sample_we",    48'(sample_we),    48'(t == 0));
    chk("fir_clr",      48'(fir_clr),      48'(t == 0));
    chk("rd_en",        48'(rd_en),        48'(t >= 1 && t <= NT));
    chk("fir_en",       48'(fir_en),       48'(t >= 2 && t <= NT + PL + 1));
    chk("coef_zero",    48'(coef_zero),    48'(t >= NT + 1 && t <= NT + PL + 1));
    chk("result_valid", 48'(result_valid), 48'(t == NT + PL + 2));
    chk("overrun",      48'(overrun),      48'(m_ovr));
    chk("result_out",   48'(result_out),   48'(m_res));
    if (t == 0) chk("load_addr", 48'(sample_addr), 48'(m_wp));
    if (t >= 1 && t <= NT) begin
      chk("coef_addr", 48'(coef_addr), 48'(t - 1));
      chk("run_addr",  48'(sample_addr), 48'(((m_wp - t + 1) % NT + NT) % NT));
    end
  endtask

  task automatic model_update();
    int t;
    bit idle;
    bit take;
    if (reset) begin
      model_reset();
      return;
    end
    idle = (m_load < 0);
    t    = idle ? -1 : cyc - m_load;
    take = data_valid_stb && seq_en;
    if (t == NT + PL + 1) m_res = exp_slice(accum_in);
    if (t == NT + PL + 2) begin
      m_load = -1;
      m_wp   = (m_wp + 1) % NT;
    end
    if (take && idle) m_load = cyc + 1;
    if (take && !idle) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
  endtask

  // One clock: check on the falling edge, advance the model, drop one-cycle strobes
  task automatic step();
    @(negedge clk);
    check_model();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    data_valid_stb = 1'b0;
    stb_s          = 1'b0;
    overrun_clr    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk(name, 48'(n < 200), 48'(1));
  endtask

  int  f_cyc [5];
  int  l_cyc [5];
  int  n_cyc [5];
  int  e_f [5] = '{1, 2, 3, 66, 74};
  int  e_l [5] = '{1, 65, 73, 73, 74};
  int  e_n [5] = '{1, 64, 71, 8, 1};
  bit  sig [5];
  int  n;
  int  rv_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (tests %0d)", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rv[0] = '{48'h0000_1234_5678, 24'h001234, 24'h001234};
    rv[1] = '{48'h0012_3456_0000, 24'h123456, 24'h123456};
    rv[2] = '{48'h0100_0000_0000, 24'h000000, 24'h7FFFFF};
    rv[3] = '{48'h8000_0000_0000, 24'h000000, 24'h800000};
    rv[4] = '{48'hFFFF_8000_0000, 24'hFF8000, 24'hFF8000};
    rv[5] = '{48'h0080_0000_0000, 24'h800000, 24'h7FFFFF};
    rv[6] = '{48'h007F_FFFF_0000, 24'h7FFFFF, 24'h7FFFFF};
    rv[7] = '{48'hFF80_0000_0000, 24'h800000, 24'h800000};
    av[0].load_addr = 2'd0; av[0].run_addr = '{2'd0, 2'd3, 2'd2, 2'd1};
    av[1].load_addr = 2'd1; av[1].run_addr = '{2'd1, 2'd0, 2'd3, 2'd2};
    av[2].load_addr = 2'd2; av[2].run_addr = '{2'd2, 2'd1, 2'd0, 2'd3};
    av[3].load_addr = 2'd3; av[3].run_addr = '{2'd3, 2'd2, 2'd1, 2'd0};
    av[4].load_addr = 2'd0; av[4].run_addr = '{2'd0, 2'd3, 2'd2, 2'd1};

    reset = 1'b1; seq_en = 1'b0; data_valid_stb = 1'b0; stb_s = 1'b0;
    overrun_clr = 1'b0; accum_in = 48'hFFFF_FFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs",   48'({sample_we, rd_en, coef_addr, sample_addr, coef_zero, fir_en,
                              fir_clr, busy, result_valid, result_out, overrun}), 48'(0));
    chk("rst_outputs_s", 48'({s_sample_we, s_rd_en, s_coef_addr, s_sample_addr, s_coef_zero, s_fir_en,
                              s_fir_clr, s_busy, s_result_valid, s_result_out, s_overrun}), 48'(0));
    reset = 1'b0;
    seq_en = 1'b1;
    model_reset();

    // Single-sample timeline, plus dropped strobes and overrun clear behaviour
    for (int i = 0; i < 5; i++) begin f_cyc[i] = -1; l_cyc[i] = -1; n_cyc[i] = 0; end
    data_valid_stb = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      step();
      sig[0] = sample_we; sig[1] = rd_en; sig[2] = fir_en; sig[3] = coef_zero; sig[4] = result_valid;
      for (int i = 0; i < 5; i++) begin
        if (sig[i]) begin
          if (f_cyc[i] < 0) f_cyc[i] = c;
          l_cyc[i] = c;
          n_cyc[i]++;
        end
      end
      if (c == 10) seq_en = 1'b0;
      if (c == 15) data_valid_stb = 1'b1;
      if (c == 16) chk("ovr_seq_en_low", 48'(overrun), 48'(0));
      if (c == 20) seq_en = 1'b1;
      if (c == 30) begin chk("ovr_before", 48'(overrun), 48'(0)); data_valid_stb = 1'b1; end
      if (c == 31) chk("ovr_set", 48'(overrun), 48'(1));
      if (c == 40) begin data_valid_stb = 1'b1; overrun_clr = 1'b1; end
      if (c == 41) begin chk("ovr_set_vs_clr", 48'(overrun), 48'(1)); overrun_clr = 1'b1; end
      if (c == 42) chk("ovr_cleared", 48'(overrun), 48'(0));
    end
    for (int i = 0; i < 5; i++) begin
      chk("first_cycle", 48'(f_cyc[i]), 48'(e_f[i]));
      chk("last_cycle",  48'(l_cyc[i]), 48'(e_l[i]));
      chk("count",       48'(n_cyc[i]), 48'(e_n[i]));
    end

    // Result scaling vectors; result_out must hold after the strobe
    foreach (rv[v]) begin
      accum_in = rv[v].acc;
      data_valid_stb = 1'b1;
      n = 0;
      step();
      while (!result_valid && n < 200) begin step(); n++; end
      chk("result_timeout", 48'(n < 200), 48'(1));
`ifdef FIR_SEQ_SATURATE_EN
      chk("result_vec", 48'(result_out), 48'(rv[v].exp_sat));
`else
      chk("result_vec", 48'(result_out), 48'(rv[v].exp_trunc));
`endif
      accum_in = {16'($urandom), $urandom};
      step();
      step();
      chk("result_hold", 48'(result_out), 48'(exp_slice(rv[v].acc)));
    end

    // 4-tap instance: delay-line addressing over five back-to-back samples
    foreach (av[v]) begin
      stb_s = 1'b1;
      step();
      chk("s_load_we",   48'(s_sample_we),   48'(1));
      chk("s_load_addr", 48'(s_sample_addr), 48'(av[v].load_addr));
      for (int j = 0; j < 4; j++) begin
        step();
        chk("s_rd_en",     48'(s_rd_en),       48'(1));
        chk("s_coef_addr", 48'(s_coef_addr),   48'(j));
        chk("s_run_addr",  48'(s_sample_addr), 48'(av[v].run_addr[j]));
      end
      n = 0;
      while (!s_result_valid && n < 30) begin step(); n++; end
      chk("s_result_timeout", 48'(n < 30), 48'(1));
      step();
    end

    // Randomized traffic against the timeline model
    for (int i = 0; i < 3000; i++) begin
      seq_en         = ($urandom % 8) != 0;
      data_valid_stb = ($urandom % 50) == 0;
      overrun_clr    = ($urandom % 40) == 0;
      accum_in       = {16'($urandom), $urandom};
      step();
    end
    seq_en = 1'b1;
    wait_idle("idle_timeout");

    // Reset in the middle of a sample: abandon it, restart from wr_ptr 0
    data_valid_stb = 1'b1;
    for (int c = 1; c <= 40; c++) step();
    chk("busy_before_reset", 48'(busy), 48'(1));
    reset = 1'b1;
    #1;
    chk("reset_async", 48'({sample_we, rd_en, coef_addr, sample_addr, coef_zero, fir_en,
                            fir_clr, busy, result_valid, result_out, overrun}), 48'(0));
    model_reset();
    step();
    reset = 1'b0;
    rv_cnt = 0;
    for (int c = 0; c < 90; c++) begin
      step();
      if (result_valid) rv_cnt++;
    end
    chk("no_result_after_reset", 48'(rv_cnt), 48'(0));
    data_valid_stb = 1'b1;
    step();
    chk("post_reset_we",   48'(sample_we),   48'(1));
    chk("post_reset_addr", 48'(sample_addr), 48'(0));
    wait_idle("final_idle_timeout");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
